// File: rtl/mem_march_pkg.sv
// Shared types and helpers for the march-test initiator.
package mem_march_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrUp,
        StRwR,
        StRwW,
        StRdDn,
        StDrain,
        StDone
    } state_e;

    localparam logic [1:0] PH_NONE  = 2'd0;
    localparam logic [1:0] PH_RW    = 2'd1;
    localparam logic [1:0] PH_RD_DN = 2'd2;

    function automatic logic is_last_addr(input int unsigned addr, input int unsigned m);
        return addr == ((32'd1 << m) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_march_initiator.sv
// Three-phase march test initiator (write up, read/write-inverse up, read down)
// with a registered compare pipeline against a single-port registered-read memory.
module mem_march_initiator
    import mem_march_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned M = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] pattern,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [M+1:0] err_count,
    output logic [M-1:0] fail_addr,
    output logic [1:0]   fail_phase,
    output logic         mem_ctrl,
    output logic [M-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    localparam logic [M-1:0] ADDR_ONE = M'(1);
    localparam logic [M+1:0] ERR_ONE  = (M + 2)'(1);

    state_e       r_state, w_state_next;
    logic [N-1:0] r_pat, w_pat_next;
    logic [M-1:0] r_addr, w_addr_next;
    logic [N-1:0] r_wdata, w_wdata_next;
    logic         r_ctrl, w_ctrl_next;
    logic         r_busy, w_busy_next;
    logic         r_done, w_done_next;
    logic         r_pass, w_pass_next;
    logic [M+1:0] r_err, w_err_next;
    logic [M-1:0] r_faddr, w_faddr_next;
    logic [1:0]   r_fphase, w_fphase_next;
    logic         r_cmp_valid, w_cmp_valid_next;
    logic [M-1:0] r_cmp_addr, w_cmp_addr_next;
    logic [N-1:0] r_cmp_exp, w_cmp_exp_next;
    logic [1:0]   r_cmp_phase, w_cmp_phase_next;

    logic w_start_ok;
    logic w_last;
    logic w_first;
    logic w_miscmp;

    assign w_start_ok = (r_state == StIdle) && start;
    assign w_last     = is_last_addr(32'(r_addr), M);
    assign w_first    = (r_addr == '0);
    assign w_miscmp   = r_cmp_valid && (mem_rdata != r_cmp_exp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StWrUp;
            StWrUp:  if (w_last) w_state_next = StRwR;
            StRwR:   w_state_next = StRwW;
            StRwW:   w_state_next = w_last ? StRdDn : StRwR;
            StRdDn:  if (w_first) w_state_next = StDrain;
            StDrain: w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_pat_next       = w_start_ok ? pattern : r_pat;
        w_addr_next      = r_addr;
        w_cmp_valid_next = 1'b0;
        w_cmp_addr_next  = r_addr;
        w_cmp_exp_next   = r_cmp_exp;
        w_cmp_phase_next = r_cmp_phase;

        unique case (r_state)
            StIdle:  if (w_start_ok) w_addr_next = '0;
            StWrUp:  w_addr_next = w_last ? '0 : r_addr + ADDR_ONE;
            StRwR: begin
                w_cmp_valid_next = 1'b1;
                w_cmp_exp_next   = r_pat;
                w_cmp_phase_next = PH_RW;
            end
            StRwW:   if (!w_last) w_addr_next = r_addr + ADDR_ONE;
            StRdDn: begin
                w_cmp_valid_next = 1'b1;
                w_cmp_exp_next   = ~r_pat;
                w_cmp_phase_next = PH_RD_DN;
                if (!w_first) w_addr_next = r_addr - ADDR_ONE;
            end
            default: w_addr_next = r_addr;
        endcase

        // Only the first miscompare of a run records where it happened.
        w_err_next    = r_err;
        w_faddr_next  = r_faddr;
        w_fphase_next = r_fphase;
        if (w_start_ok) begin
            w_err_next    = '0;
            w_faddr_next  = '0;
            w_fphase_next = PH_NONE;
        end else if (w_miscmp) begin
            w_err_next = r_err + ERR_ONE;
            if (r_err == '0) begin
                w_faddr_next  = r_cmp_addr;
                w_fphase_next = r_cmp_phase;
            end
        end

        w_pass_next = r_pass;
        if (w_start_ok) begin
            w_pass_next = 1'b0;
        end else if (r_state == StDrain) begin
            w_pass_next = (w_err_next == '0);
        end

        // Memory and status outputs are registered from the next state so they align with it.
        w_wdata_next = r_wdata;
        if (w_state_next == StWrUp) begin
            w_wdata_next = w_pat_next;
        end else if (w_state_next == StRwW) begin
            w_wdata_next = ~r_pat;
        end
        w_ctrl_next = !(w_state_next inside {StWrUp, StRwW});
        w_busy_next = !(w_state_next inside {StIdle, StDone});
        w_done_next = (w_state_next == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ctrl      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_faddr     <= '0;
            r_fphase    <= PH_NONE;
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_exp   <= '0;
            r_cmp_phase <= PH_NONE;
        end else begin
            r_pat       <= w_pat_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_ctrl      <= w_ctrl_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_pass      <= w_pass_next;
            r_err       <= w_err_next;
            r_faddr     <= w_faddr_next;
            r_fphase    <= w_fphase_next;
            r_cmp_valid <= w_cmp_valid_next;
            r_cmp_addr  <= w_cmp_addr_next;
            r_cmp_exp   <= w_cmp_exp_next;
            r_cmp_phase <= w_cmp_phase_next;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_addr  = r_faddr;
    assign fail_phase = r_fphase;
    assign mem_ctrl   = r_ctrl;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule
